// File: rtl/zb_dl_pkg.sv
// Shared constants and stage payload type for the ZigBee alignment delay line.
package zb_dl_pkg;

    localparam int unsigned DL_WIDTH_DEF = 8;
    localparam int unsigned DL_DEPTH_DEF = 16;

    // Default-width stage payload; wider/narrower instances re-declare it from WIDTH.
    typedef struct packed {
        logic                    valid;
        logic [DL_WIDTH_DEF-1:0] data;
    } dl_stage_t;

endpackage

// File: rtl/zb_dl_stage.sv
// One {valid, data} register stage: async clear, synchronous flush, shift enable.
module zb_dl_stage
    import zb_dl_pkg::*;
#(
    parameter type stage_t = dl_stage_t
) (
    input  logic   i_CLK,
    input  logic   i_RST,
    input  logic   i_EN,
    input  logic   i_CLR,
    input  stage_t i_D,
    output stage_t o_Q
);

    // Flush outranks enable so a sample presented with i_CLR is dropped.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            o_Q <= '0;
        end else if (i_CLR) begin
            o_Q <= '0;
        end else if (i_EN) begin
            o_Q <= i_D;
        end
    end

endmodule

// File: rtl/zb_delay_line.sv
// Enable-controlled, flushable delay line with runtime tap select, fill count and
// out-of-range delay flag; aligns chip/symbol streams in the ZigBee datapath.
module zb_delay_line
    import zb_dl_pkg::*;
#(
    parameter int unsigned WIDTH = DL_WIDTH_DEF,
    parameter int unsigned DEPTH = DL_DEPTH_DEF,
    parameter int unsigned SELW  = $clog2(DEPTH + 1)
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_EN,
    input  logic             i_CLR,
    input  logic [WIDTH-1:0] i_DATA,
    input  logic             i_VALID,
    input  logic [SELW-1:0]  i_DELAY,
    output logic [WIDTH-1:0] o_DATA,
    output logic             o_VALID,
    output logic [SELW-1:0]  o_FILL,
    output logic             o_DLY_ERR
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    // Index 0 is the live input, so a delay of 0 selects the bypass directly.
    stage_t          stg [DEPTH+1];
    stage_t          tap;
    logic            dly_over;
    logic [SELW-1:0] fill;
    logic            dly_err;

    assign stg[0] = '{valid: i_VALID, data: i_DATA};

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        zb_dl_stage #(
            .stage_t(stage_t)
        ) u_stage (
            .i_CLK(i_CLK),
            .i_RST(i_RST),
            .i_EN (i_EN),
            .i_CLR(i_CLR),
            .i_D  (stg[k-1]),
            .o_Q  (stg[k])
        );
    end

    assign dly_over = i_DELAY > SELW'(DEPTH);

    // Out-of-range requests clamp to the last stage.
    always_comb begin
        tap = stg[DEPTH];
        if (!dly_over) begin
            tap = stg[i_DELAY];
        end
    end

    always_comb begin
        fill = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            fill = fill + SELW'(stg[k].valid);
        end
    end

    // Not sticky: reflects only the request seen at the most recent edge.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            dly_err <= 1'b0;
        end else begin
            dly_err <= dly_over;
        end
    end

    assign o_VALID   = tap.valid;
    assign o_DATA    = tap.valid ? tap.data : '0;
    assign o_FILL    = fill;
    assign o_DLY_ERR = dly_err;

endmodule

// File: tb/tb_zb_delay_line.sv
// Directed, table-driven bench for zb_delay_line at WIDTH=8, DEPTH=16.
module tb_zb_delay_line;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [7:0] din;
    logic       vin;
    logic [4:0] dly;
    logic [7:0] dout;
    logic       vout;
    logic [4:0] fill;
    logic       err;

    int n_total;
    int n_pass;

    typedef struct {
        logic       en;
        logic       clr;
        logic       v;
        logic [7:0] d;
        logic [4:0] dly;
        logic       ev;
        logic [7:0] ed;
        logic [4:0] ef;
        logic       ee;
    } vec_t;

    vec_t tbl[$];

    zb_delay_line dut (
        .i_CLK    (clk),
        .i_RST    (rst),
        .i_EN     (en),
        .i_CLR    (clr),
        .i_DATA   (din),
        .i_VALID  (vin),
        .i_DELAY  (dly),
        .o_DATA   (dout),
        .o_VALID  (vout),
        .o_FILL   (fill),
        .o_DLY_ERR(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    endtask

    task automatic chk(input string tag, input logic ev, input logic [7:0] ed,
                       input logic [4:0] ef, input logic ee);
        check({tag, ".valid"}, 8'(vout), 8'(ev));
        check({tag, ".data"},  dout,     ed);
        check({tag, ".fill"},  8'(fill), 8'(ef));
        check({tag, ".err"},   8'(err),  8'(ee));
    endtask

    task automatic drive(input logic e, input logic c, input logic v,
                         input logic [7:0] d, input logic [4:0] s);
        en = e; clr = c; vin = v; din = d; dly = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic c, input logic v, input logic [7:0] d,
                       input logic [4:0] s, input logic ev, input logic [7:0] ed,
                       input logic [4:0] ef, input logic ee);
        vec_t r;
        r.en = e; r.clr = c; r.v = v; r.d = d; r.dly = s;
        r.ev = ev; r.ed = ed; r.ef = ef; r.ee = ee;
        tbl.push_back(r);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 5'd4);

        // Reset state, then bypass while held in reset.
        #2;
        chk("reset", 1'b0, 8'h00, 5'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h5A, 5'd0);
        #1;
        chk("reset_bypass", 1'b1, 8'h5A, 5'd0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 5'd4);
        tick();

        // Fill ramp at delay 4: row i sees data 1..i already shifted in.
        for (int i = 0; i < 18; i++) begin
            add(1'b1, 1'b0, 1'b1, 8'(i + 1), 5'd4, (i >= 4), (i >= 4) ? 8'(i - 3) : 8'h00,
                (i < 16) ? 5'(i) : 5'd16, 1'b0);
        end
        // Pipeline now s1=18 .. s16=3. Bypass, clamp, exact-depth tap, error flag timing.
        add(1'b0, 1'b0, 1'b1, 8'hA5, 5'd0,  1'b1, 8'hA5, 5'd16, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 5'd20, 1'b1, 8'h03, 5'd16, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 5'd20, 1'b1, 8'h03, 5'd16, 1'b1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 5'd3,  1'b1, 8'h10, 5'd16, 1'b1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 5'd3,  1'b1, 8'h10, 5'd16, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h77, 5'd0,  1'b0, 8'h00, 5'd16, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 5'd16, 1'b1, 8'h03, 5'd16, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 5'd16, 1'b1, 8'h03, 5'd16, 1'b0);
        // Stall for 5 cycles at delay 3, then resume without loss or repeat.
        add(1'b1, 1'b0, 1'b1, 8'd19, 5'd3,  1'b1, 8'd16, 5'd16, 1'b0);
        for (int i = 0; i < 5; i++) begin
            add(1'b0, 1'b0, 1'b1, 8'd20, 5'd3, 1'b1, 8'd17, 5'd16, 1'b0);
        end
        add(1'b1, 1'b0, 1'b1, 8'd20, 5'd3,  1'b1, 8'd17, 5'd16, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'd21, 5'd3,  1'b1, 8'd18, 5'd16, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'd22, 5'd3,  1'b1, 8'd19, 5'd16, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 5'd3,  1'b1, 8'd20, 5'd16, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].v, tbl[i].d, tbl[i].dly);
            #1;
            chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ef, tbl[i].ee);
            tick();
        end

        // Flush priority: load 0x10..0x1F, then clear with enable and 0xFF present.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 5'd1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 5'd16);
        #1;
        chk("full_s16", 1'b1, 8'h10, 5'd16, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 5'd1);
        #1;
        chk("clr_pre", 1'b1, 8'h1F, 5'd16, 1'b0);
        tick();
        for (int s = 1; s <= 16; s++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 5'(s));
            #1;
            chk($sformatf("flushed_tap%0d", s), 1'b0, 8'h00, 5'd0, 1'b0);
        end

        // Async reset between edges, then 0x33 through delay 2.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 5'd2);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 5'd2);
        #1;
        chk("pre_rst", 1'b1, 8'h43, 5'd5, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst", 1'b0, 8'h00, 5'd0, 1'b0);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'h33, 5'd2);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 5'd2);
        #1;
        chk("post_rst_e1", 1'b0, 8'h00, 5'd1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 5'd2);
        #1;
        chk("post_rst_e2", 1'b1, 8'h33, 5'd1, 1'b0);

        // Sparse valid at delay 5: invalid words carry 0x55 but must read as 0.
        drive(1'b0, 1'b1, 1'b0, 8'h00, 5'd5);
        tick();
        for (int j = 0; j < 22; j++) begin
            drive(1'b1, 1'b0, (j % 2 == 0), 8'h55, 5'd5);
            #1;
            chk($sformatf("sparse%0d", j), (j >= 5) && (j % 2 == 1),
                ((j >= 5) && (j % 2 == 1)) ? 8'h55 : 8'h00,
                (j < 16) ? 5'((j + 1) / 2) : 5'd8, 1'b0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/zb_delay_line.md
Name: zb_delay_line

Overview:
- Parametrised, enable-controlled, flushable register delay line carrying data plus a valid flag.
- Successor to the single-bit flip-flop. Generalised in WIDTH and DEPTH, with a runtime-selectable tap, stall, synchronous flush and fill count.
- Used in the ZigBee datapath to align chip/symbol streams between the spreader, the O-QPSK modulator and the correlator paths.

Parameters:
- WIDTH, 8, data bits per stage (1..32).
- DEPTH, 16, number of register stages (1..64).
- SELW, $clog2(DEPTH+1), width of delay select and fill count.

Ports:
- i_CLK  in  1  system clock, rising edge.
- i_RST  in  1  asynchronous active-low reset.
- i_EN  in  1  shift enable. 0 = all stages hold.
- i_CLR  in  1  synchronous flush.
- i_DATA  in  WIDTH  input sample.
- i_VALID  in  1  input sample valid.
- i_DELAY  in  SELW  requested delay in cycles of i_EN (0..DEPTH).
- o_DATA  out  WIDTH  delayed sample.
- o_VALID  out  1  delayed sample valid.
- o_FILL  out  SELW  number of stages currently holding valid data.
- o_DLY_ERR  out  1  registered flag: i_DELAY exceeded DEPTH on the previous edge.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset (i_RST=0, asynchronous):
  - All stage data cleared to 0 and all stage valids cleared to 0.
  - o_DLY_ERR=0 and o_FILL=0.
  - o_VALID=0 unless i_DELAY=0 (bypass path, see tap select).
- Stage array: s[1..DEPTH], each holding {valid, data}.
- Clock-edge priority, evaluated top to bottom:
  1. i_CLR=1: every s[k] is set to {0,0}, regardless of i_EN.
  2. Else if i_EN=1: s[1] takes {i_VALID, i_DATA}, and s[k] takes s[k-1] for k=2..DEPTH. The data word shifts even when its valid is 0.
  3. Else: all stages hold.
- Tap select (combinational):
  - i_DELAY=0: bypass. o_VALID=i_VALID and o_DATA=i_DATA.
  - 1<=i_DELAY<=DEPTH: output is s[i_DELAY].
  - i_DELAY>DEPTH: clamped to s[DEPTH].
- Data gating: o_DATA is forced to 0 whenever o_VALID=0, including during the bypass.
- Latency: with i_EN held at 1, a sample presented at edge n appears at the output after edge n+d-1, i.e. it is visible during cycle n+d for delay d. When i_EN is gated, latency counts enabled edges only.
- o_DLY_ERR: on every edge it samples (i_DELAY>DEPTH). It is not sticky.
- o_FILL: popcount of s[1..DEPTH].valid, combinational from the stage flops. Range 0..DEPTH, never wraps.
- i_DELAY changed mid-stream: takes effect in the same cycle. There is no re-alignment, and downstream is responsible for discarding the transient.
- i_CLR and i_EN both 1: the flush wins and the input sample is dropped.
- Reset asserted mid-stream: all contents are lost immediately, with no wait for a clock edge. After release, the first edge with i_EN=1 loads s[1] normally.

Decomposition:
- Package zb_dl_pkg holds:
  - Default constants: DL_WIDTH_DEF=8, DL_DEPTH_DEF=16.
  - Typedef dl_stage_t, a packed struct {logic valid; logic [WIDTH-1:0] data}, declared via a parametrised width constant.
- Sub-module zb_dl_stage: one register stage with asynchronous active-low reset, enable and synchronous clear. It is instantiated DEPTH times by a generate loop.
- The top level contains the tap mux, popcount and error flag.

Test Plan:
- Reset then fill: i_EN=1, i_VALID=1, i_DATA=0x01,0x02,..., i_DELAY=4 → first o_VALID=1 with o_DATA=0x01 in cycle 4. o_FILL ramps 1..16 and saturates at 16.
- Bypass and clamp:
  - i_DELAY=0 with i_DATA=0xA5, i_VALID=1 → o_DATA=0xA5 in the same cycle.
  - i_DELAY=20 → output equals s[16], and o_DLY_ERR=1 after the next edge. It returns to 0 one edge after i_DELAY=3.
- Stall: i_EN=0 for 5 cycles mid-stream at i_DELAY=3 → o_DATA/o_VALID frozen and o_FILL constant. On resume, the sequence continues with no loss or duplication.
- Flush priority: pipeline full of 0x10..0x1F, then i_CLR=1 with i_EN=1 and i_DATA=0xFF → o_FILL=0 and o_VALID=0 after the edge. 0xFF never appears at any tap.
- Asynchronous reset mid-stream: pull i_RST low between edges → o_VALID=0, o_DATA=0 and o_FILL=0 before the next rising edge. After release, 0x33 at i_DELAY=2 appears 2 enabled edges later.
- Sparse valid: alternating i_VALID=1/0 with i_DATA=0x55 on every cycle, i_DELAY=5 → o_DATA=0x00 whenever o_VALID=0, and o_FILL settles at 8.
